// File: rtl/l1_pmem_arbiter_if.sv
// Line-port bundle shared by the icache, the dcache and the downstream pmem/L2 side.
interface l1_pmem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rdata;
   logic              resp;

   // Issuing side (the arbiter toward pmem).
   modport master (output read, write, address, wdata, input rdata, resp);
   // Serving side for a requester that can also write back (dcache).
   modport slave (input read, write, address, wdata, output rdata, resp);
   // Serving side for a read-only requester (icache).
   modport slave_ro (input read, address, output rdata, resp);
endinterface

// File: rtl/l1_pmem_arbiter.sv
// Arbitrates the shared pmem line port between L1 icache and dcache, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives dcache fixed priority.
module l1_pmem_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   l1_pmem_arbiter_if.slave_ro  i_pmem,
   l1_pmem_arbiter_if.slave     d_pmem,
   l1_pmem_arbiter_if.master    pmem
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              i_req, d_req, grant_d;

   assign i_req = i_pmem.read;
   assign d_req = d_pmem.read | d_pmem.write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;

   // On a tie, the side that did not win last time goes next.
   assign grant_d = d_req & (~i_req | ~last_d_q);
`else
   assign grant_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= last_d_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      i_pmem.resp = 1'b0;
      d_pmem.resp = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d    = last_d_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_d) begin
               // Read+write together is illegal; treat it as a writeback.
               state_d = ST_SERVE_D;
               rd_d    = ~d_pmem.write;
               wr_d    = d_pmem.write;
               addr_d  = d_pmem.address;
               wdata_d = d_pmem.wdata;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = 1'b1;
`endif
            end else if (i_req) begin
               state_d = ST_SERVE_I;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               addr_d  = i_pmem.address;
               wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = 1'b0;
`endif
            end
         end
         ST_SERVE_I: begin
            if (pmem.resp) begin
               i_pmem.resp = 1'b1;
               rd_d        = 1'b0;
               wr_d        = 1'b0;
               state_d     = ST_DONE;
            end
         end
         ST_SERVE_D: begin
            if (pmem.resp) begin
               d_pmem.resp = 1'b1;
               rd_d        = 1'b0;
               wr_d        = 1'b0;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes come only from the latched transaction, never from live requester inputs.
   assign pmem.read     = rd_q;
   assign pmem.write    = wr_q;
   assign pmem.address  = addr_q;
   assign pmem.wdata    = wdata_q;
   assign i_pmem.rdata  = pmem.rdata;
   assign d_pmem.rdata  = pmem.rdata;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Randomized bench for l1_pmem_arbiter against a transaction-level model of the shared port.
module tb_l1_pmem_arbiter;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned N_CYC  = 4000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   l1_pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
   l1_pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
   l1_pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) p_bus ();

   l1_pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .i_pmem (i_bus),
      .d_pmem (d_bus),
      .pmem   (p_bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Model: the port is either busy with one latched transaction or free;
   // after a completion it stays unavailable for one turnaround cycle.
   bit                m_busy, m_wr, m_own_d, m_last_d;
   int                m_gap;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;

   bit i_act, d_act, i_done, d_done, was_reset, sched;
   bit exp_iresp, exp_dresp, ireq, dreq, win_d;
   int lat;
   int unsigned op;

   initial begin
      reset         = 1'b1;
      i_bus.read    = 1'b0;
      i_bus.write   = 1'b0;
      i_bus.address = '0;
      i_bus.wdata   = '0;
      d_bus.read    = 1'b0;
      d_bus.write   = 1'b0;
      d_bus.address = '0;
      d_bus.wdata   = '0;
      p_bus.rdata   = rand_line();
      p_bus.resp    = 1'b1;
      m_busy = 0; m_wr = 0; m_own_d = 0; m_last_d = 1; m_gap = 0;
      m_addr = '0; m_wdata = '0;
      sched = 0; lat = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_pmem_read",  LINE_W'(p_bus.read),  '0);
      check_eq("rst_pmem_write", LINE_W'(p_bus.write), '0);
      check_eq("rst_i_resp",     LINE_W'(i_bus.resp),  '0);
      check_eq("rst_d_resp",     LINE_W'(d_bus.resp),  '0);
      check_eq("rst_pmem_addr",  LINE_W'(p_bus.address), '0);

      // First arbitration after reset is a tie.
      @(posedge clk); #1;
      reset         = 1'b0;
      p_bus.resp    = 1'b0;
      i_bus.read    = 1'b1;
      i_bus.address = 16'h1000;
      d_bus.read    = 1'b1;
      d_bus.address = 16'h2000;
      i_act = 1; d_act = 1;

      for (int c = 0; c < int'(N_CYC); c++) begin
         @(negedge clk);
         exp_iresp = m_busy && !m_own_d && (p_bus.resp === 1'b1);
         exp_dresp = m_busy &&  m_own_d && (p_bus.resp === 1'b1);
         check_eq("pmem_read",  LINE_W'(p_bus.read),  LINE_W'(m_busy && !m_wr));
         check_eq("pmem_write", LINE_W'(p_bus.write), LINE_W'(m_busy && m_wr));
         check_eq("i_resp",     LINE_W'(i_bus.resp),  LINE_W'(exp_iresp));
         check_eq("d_resp",     LINE_W'(d_bus.resp),  LINE_W'(exp_dresp));
         if (m_busy) check_eq("pmem_address", LINE_W'(p_bus.address), LINE_W'(m_addr));
         if (m_busy && m_wr) check_eq("pmem_wdata", p_bus.wdata, m_wdata);
         if (exp_iresp) check_eq("i_rdata", i_bus.rdata, p_bus.rdata);
         if (exp_dresp) check_eq("d_rdata", d_bus.rdata, p_bus.rdata);
         i_done = exp_iresp;
         d_done = exp_dresp;

         // Advance the model by one cycle using the inputs seen this cycle.
         if (reset) begin
            m_busy = 0; m_gap = 0; m_last_d = 1;
         end else if (m_busy) begin
            if (p_bus.resp) begin
               m_busy = 0;
               m_gap  = 1;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else begin
            ireq = i_bus.read;
            dreq = d_bus.read || d_bus.write;
`ifdef ARB_ROUND_ROBIN_EN
            win_d = (ireq && dreq) ? !m_last_d : dreq;
`else
            win_d = dreq;
`endif
            if (ireq || dreq) begin
               m_busy   = 1;
               m_own_d  = win_d;
               m_last_d = win_d;
               if (win_d) begin
                  m_wr    = d_bus.write;
                  m_addr  = d_bus.address;
                  m_wdata = d_bus.wdata;
               end else begin
                  m_wr   = 0;
                  m_addr = i_bus.address;
               end
            end
         end
         was_reset = reset;

         @(posedge clk); #1;
         reset = ($urandom_range(0, 299) == 0);
         if (was_reset) begin
            i_act = 0; d_act = 0; sched = 0;
            i_bus.read = 1'b0; d_bus.read = 1'b0; d_bus.write = 1'b0;
         end

         if (i_done) begin
            i_act = 0;
            i_bus.read = 1'b0;
         end else if (!i_act && $urandom_range(0, 3) == 0) begin
            i_act = 1;
            i_bus.read    = 1'b1;
            i_bus.address = ADDR_W'($urandom());
         end else if (i_act && m_busy && !m_own_d && $urandom_range(0, 5) == 0) begin
            i_bus.address = ADDR_W'($urandom());
            i_bus.read    = 1'($urandom_range(0, 1));
         end

         if (d_done) begin
            d_act = 0;
            d_bus.read  = 1'b0;
            d_bus.write = 1'b0;
         end else if (!d_act && $urandom_range(0, 3) == 0) begin
            d_act = 1;
            op = $urandom_range(0, 7);
            d_bus.read    = (op < 4) || (op == 7);
            d_bus.write   = (op >= 4);
            d_bus.address = ADDR_W'($urandom());
            d_bus.wdata   = rand_line();
         end else if (d_act && m_busy && m_own_d && $urandom_range(0, 5) == 0) begin
            d_bus.address = ADDR_W'($urandom());
            d_bus.wdata   = rand_line();
            d_bus.read    = 1'($urandom_range(0, 1));
            d_bus.write   = 1'b0;
         end

         // Downstream answers each transaction after 0..3 extra cycles; stray resps when free.
         p_bus.rdata = rand_line();
         if (m_busy && !sched) begin
            sched = 1;
            lat   = $urandom_range(0, 3);
         end
         if (sched && lat == 0) begin
            p_bus.resp = 1'b1;
            sched = 0;
         end else begin
            if (sched) lat--;
            p_bus.resp = !m_busy && ($urandom_range(0, 7) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
